// File: rtl/reg_resp_pkg.sv
// Shared definitions for the register responder: command encoding, address map,
// CTRL field layout and ERR_STAT bit positions.
package reg_resp_pkg;

   typedef enum logic [1:0] {
      CMD_IDLE = 2'b00,
      CMD_WR   = 2'b01,
      CMD_RD   = 2'b10
   } cmd_e;

   localparam int unsigned CTRL_BASE     = 32'h00;
   localparam int unsigned STAT_BASE     = 32'h10;
   localparam int unsigned ERR_STAT_ADDR = 32'h20;
   localparam int unsigned ERR_CNT_ADDR  = 32'h24;
   localparam int unsigned LOCK_ADDR     = 32'h28;

   localparam int unsigned CTRL_EN_OFF   = 0;
   localparam int unsigned CTRL_PRIO_OFF = 1;
   localparam int unsigned CTRL_PRIO_W   = 2;
   localparam int unsigned CTRL_LEN_OFF  = 3;
   localparam int unsigned CTRL_LEN_W    = 3;
   localparam int unsigned CTRL_W        = 6;

   localparam int unsigned STAT_W        = 8;

   localparam int unsigned ERR_RO_BIT    = 0;
   localparam int unsigned ERR_UNMAP_BIT = 1;
   localparam int unsigned ERR_LOCK_BIT  = 2;
   localparam int unsigned ERR_W         = 3;

endpackage

// File: rtl/reg_resp_ctrl_reg.sv
// One per-channel CTRL register: 6 stored bits split into en / prio / pkt_len fields.
module reg_resp_ctrl_reg
   import reg_resp_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   we_i,
   input  logic [CTRL_W-1:0]      wdata_i,
   output logic [CTRL_W-1:0]      value_o,
   output logic                   en_o,
   output logic [CTRL_PRIO_W-1:0] prio_o,
   output logic [CTRL_LEN_W-1:0]  pkt_len_o
);

   logic [CTRL_W-1:0] ctrl_q;
   logic [CTRL_W-1:0] ctrl_d;

   always_comb begin
      ctrl_d = ctrl_q;
      if (we_i) begin
         ctrl_d = wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q <= '0;
      end else begin
         ctrl_q <= ctrl_d;
      end
   end

   assign value_o   = ctrl_q;
   assign en_o      = ctrl_q[CTRL_EN_OFF];
   assign prio_o    = ctrl_q[CTRL_PRIO_OFF +: CTRL_PRIO_W];
   assign pkt_len_o = ctrl_q[CTRL_LEN_OFF +: CTRL_LEN_W];

endmodule

// File: rtl/reg_responder.sv
// Register-slave end of the cmd/cmd_addr command bus: CTRL/STAT per channel, sticky
// error status and saturating error counter. REG_RESP_WR_LOCK_EN adds a CTRL write lock at 0x28.
module reg_responder
   import reg_resp_pkg::*;
#(
   parameter int unsigned NUM_CH = 3,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            cmd,
   input  logic [ADDR_W-1:0]     cmd_addr,
   input  logic [DATA_W-1:0]     cmd_data_s2m,
   output logic [DATA_W-1:0]     cmd_data_m2s,
   input  logic [8*NUM_CH-1:0]   ch_margin,
   output logic [NUM_CH-1:0]     ch_en,
   output logic [2*NUM_CH-1:0]   ch_prio,
   output logic [3*NUM_CH-1:0]   ch_pkt_len
);

   logic [CTRL_W-1:0] ctrl_val [NUM_CH];
   logic [NUM_CH-1:0] ctrl_we;

   logic [ERR_W-1:0]  err_stat_q, err_stat_d;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic              is_wr, is_rd, aligned;
   logic              ctrl_hit, stat_hit, err_stat_hit, err_cnt_hit, lock_hit, locked;
   logic [1:0]        ch_idx;
   logic [ERR_W-1:0]  err_set, err_clr;
   logic [DATA_W-1:0] rd_val;

`ifdef REG_RESP_WR_LOCK_EN
   logic lock_q, lock_d;
`endif

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      reg_resp_ctrl_reg u_ctrl (
         .clk       (clk),
         .rst       (rst),
         .we_i      (ctrl_we[n]),
         .wdata_i   (cmd_data_s2m[CTRL_W-1:0]),
         .value_o   (ctrl_val[n]),
         .en_o      (ch_en[n]),
         .prio_o    (ch_prio[2*n +: 2]),
         .pkt_len_o (ch_pkt_len[3*n +: 3])
      );
   end

   // Address decode, write/clear effects, read mux and error accounting
   always_comb begin
      is_wr        = (cmd == CMD_WR);
      is_rd        = (cmd == CMD_RD);
      aligned      = (cmd_addr[1:0] == 2'b00);
      ch_idx       = cmd_addr[3:2];
      ctrl_hit     = aligned && (cmd_addr < ADDR_W'(CTRL_BASE + 4 * NUM_CH));
      stat_hit     = aligned && (cmd_addr >= ADDR_W'(STAT_BASE))
                             && (cmd_addr < ADDR_W'(STAT_BASE + 4 * NUM_CH));
      err_stat_hit = (cmd_addr == ADDR_W'(ERR_STAT_ADDR));
      err_cnt_hit  = (cmd_addr == ADDR_W'(ERR_CNT_ADDR));
      lock_hit     = 1'b0;
      locked       = 1'b0;
      ctrl_we      = '0;
      err_set      = '0;
      err_clr      = '0;
      rd_val       = '0;
`ifdef REG_RESP_WR_LOCK_EN
      lock_hit     = (cmd_addr == ADDR_W'(LOCK_ADDR));
      locked       = lock_q;
      lock_d       = lock_q;
`endif

      if (is_wr) begin
         if (ctrl_hit) begin
            if (locked) begin
               err_set[ERR_LOCK_BIT] = 1'b1;
            end else begin
               for (int n = 0; n < NUM_CH; n++) begin
                  ctrl_we[n] = (ch_idx == 2'(n));
               end
            end
         end else if (stat_hit || err_cnt_hit) begin
            err_set[ERR_RO_BIT] = 1'b1;
         end else if (err_stat_hit) begin
            err_clr = cmd_data_s2m[ERR_W-1:0];
         end else if (lock_hit) begin
`ifdef REG_RESP_WR_LOCK_EN
            lock_d = cmd_data_s2m[0];
`endif
         end else begin
            err_set[ERR_UNMAP_BIT] = 1'b1;
         end
      end else if (is_rd) begin
         if (ctrl_hit) begin
            for (int n = 0; n < NUM_CH; n++) begin
               if (ch_idx == 2'(n)) rd_val = DATA_W'(ctrl_val[n]);
            end
         end else if (stat_hit) begin
            for (int n = 0; n < NUM_CH; n++) begin
               if (ch_idx == 2'(n)) rd_val = DATA_W'(ch_margin[STAT_W*n +: STAT_W]);
            end
         end else if (err_stat_hit) begin
            rd_val = DATA_W'(err_stat_q);
         end else if (err_cnt_hit) begin
            rd_val = DATA_W'(err_cnt_q);
         end else if (lock_hit) begin
`ifdef REG_RESP_WR_LOCK_EN
            rd_val = DATA_W'(lock_q);
`endif
         end else begin
            err_set[ERR_UNMAP_BIT] = 1'b1;
         end
      end

      // A new error on a bit beats a simultaneous W1C of that bit
      err_stat_d = err_set | (err_stat_q & ~err_clr);
      err_cnt_d  = ((|err_set) && (err_cnt_q != '1)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
      rdata_d    = is_rd ? rd_val : rdata_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_stat_q <= '0;
         err_cnt_q  <= '0;
         rdata_q    <= '0;
`ifdef REG_RESP_WR_LOCK_EN
         lock_q     <= 1'b0;
`endif
      end else begin
         err_stat_q <= err_stat_d;
         err_cnt_q  <= err_cnt_d;
         rdata_q    <= rdata_d;
`ifdef REG_RESP_WR_LOCK_EN
         lock_q     <= lock_d;
`endif
      end
   end

   assign cmd_data_m2s = rdata_q;

endmodule

// File: tb/tb_reg_responder.sv
// Randomised scoreboard bench for reg_responder against an address-map level model.
module tb_reg_responder;

   localparam int NUM_CH = 3;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 16;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef REG_RESP_WR_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst;
   logic [1:0]          cmd;
   logic [ADDR_W-1:0]   cmd_addr;
   logic [DATA_W-1:0]   cmd_data_s2m;
   logic [DATA_W-1:0]   cmd_data_m2s;
   logic [8*NUM_CH-1:0] ch_margin;
   logic [NUM_CH-1:0]   ch_en;
   logic [2*NUM_CH-1:0] ch_prio;
   logic [3*NUM_CH-1:0] ch_pkt_len;

   reg_responder #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd          (cmd),
      .cmd_addr     (cmd_addr),
      .cmd_data_s2m (cmd_data_s2m),
      .cmd_data_m2s (cmd_data_m2s),
      .ch_margin    (ch_margin),
      .ch_en        (ch_en),
      .ch_prio      (ch_prio),
      .ch_pkt_len   (ch_pkt_len)
   );

   always #5 clk = ~clk;

   // Reference model: register contents as plain integers
   int          m_ctrl [NUM_CH];
   int          m_err;
   int          m_cnt;
   int          m_lock;
   logic [31:0] exp_q [$];
   logic [31:0] held;
   int          checks = 0;
   int          errors = 0;

   // 0 ctrl, 1 stat, 2 err_stat, 3 err_cnt, 4 lock, 5 unmapped
   function automatic int region(input int a);
      if (a % 4 != 0) return 5;
      if (a < 4 * NUM_CH) return 0;
      if (a >= 16 && a < 16 + 4 * NUM_CH) return 1;
      if (a == 32) return 2;
      if (a == 36) return 3;
      if (a == 40 && LOCK_EN) return 4;
      return 5;
   endfunction

   function automatic logic [31:0] model_read(input int a, input logic [8*NUM_CH-1:0] mg);
      case (region(a))
         0: return 32'(m_ctrl[a / 4]);
         1: return 32'((mg >> (8 * ((a - 16) / 4))) & 'hFF);
         2: return 32'(m_err);
         3: return 32'(m_cnt);
         4: return 32'(m_lock);
         default: return 32'h0;
      endcase
   endfunction

   function automatic void raise(input int bitpos);
      m_err = m_err | (1 << bitpos);
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
   endfunction

   function automatic void model_reset();
      for (int n = 0; n < NUM_CH; n++) m_ctrl[n] = 0;
      m_err = 0; m_cnt = 0; m_lock = 0;
   endfunction

   function automatic void model_apply(input int c, input int a, input logic [31:0] d);
      int r = region(a);
      if (c == 1) begin
         case (r)
            0: if (m_lock != 0) raise(2); else m_ctrl[a / 4] = int'(d % 64);
            1, 3: raise(0);
            2: m_err = m_err & ~int'(d % 8);
            4: m_lock = int'(d % 2);
            default: raise(1);
         endcase
      end else if (c == 2 && r == 5) begin
         raise(1);
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic issue(input logic r, input logic [1:0] c, input int a, input logic [31:0] d);
      rst = r; cmd = c; cmd_addr = 8'(a); cmd_data_s2m = d;
      if (!r && c == 2'b10) exp_q.push_back(model_read(a, ch_margin));
      @(posedge clk);
      if (r) model_reset(); else model_apply(int'(c), a, d);
      #1;
   endtask

   // Monitor: read data appears the cycle after a sampled RD and is held otherwise
   bit rd_seen = 1'b0;
   bit rst_seen = 1'b0;
   always @(posedge clk) begin
      rd_seen  <= (cmd == 2'b10) && (rst == 1'b0);
      rst_seen <= (rst == 1'b1);
   end

   always @(negedge clk) begin
      logic [NUM_CH-1:0]   e_en;
      logic [2*NUM_CH-1:0] e_prio;
      logic [3*NUM_CH-1:0] e_len;
      if (rst_seen) begin
         held = '0;
      end else if (rd_seen) begin
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_underflow no expected read queued at %0t", $time);
         end else begin
            held = exp_q.pop_front();
         end
      end
      chk("rdata", cmd_data_m2s, held);
      for (int n = 0; n < NUM_CH; n++) begin
         e_en[n]          = 1'(m_ctrl[n] % 2);
         e_prio[2*n +: 2] = 2'((m_ctrl[n] / 2) % 4);
         e_len[3*n +: 3]  = 3'((m_ctrl[n] / 8) % 8);
      end
      chk("ch_outputs", {8'h0, ch_pkt_len, ch_prio, ch_en}, {8'h0, e_len, e_prio, e_en});
   end

   initial begin
      ch_margin = '0;
      model_reset();
      held = '0;
      issue(1, 0, 0, 0);
      issue(1, 0, 0, 0);
      // reset state reads
      issue(0, 2, 'h00, 0);
      issue(0, 2, 'h20, 0);
      issue(0, 2, 'h24, 0);
      issue(0, 0, 0, 0);
      // CTRL write then immediate read-back
      issue(0, 1, 'h04, 32'hFFFF_FFFF);
      issue(0, 2, 'h04, 0);
      issue(0, 0, 0, 0);
      // STAT read and write-to-RO
      ch_margin[23:16] = 8'h5A;
      issue(0, 2, 'h18, 0);
      issue(0, 1, 'h18, 1);
      issue(0, 2, 'h20, 0);
      issue(0, 2, 'h24, 0);
      issue(0, 2, 'h18, 0);
      // unmapped read, W1C of bit0 only, misaligned, reserved cmd
      issue(0, 2, 'h3C, 0);
      issue(0, 1, 'h20, 1);
      issue(0, 2, 'h30, 0);
      issue(0, 2, 'h20, 0);
      issue(0, 2, 'h24, 0);
      issue(0, 2, 'h01, 0);
      issue(0, 3, 'h3C, 32'hFFFF_FFFF);
      issue(0, 2, 'h0C, 0);
      issue(0, 2, 'h24, 0);
      issue(0, 1, 'h20, 32'hFFFF_FFFF);
      issue(0, 2, 'h20, 0);
`ifdef REG_RESP_WR_LOCK_EN
      issue(0, 1, 'h28, 1);
      issue(0, 1, 'h00, 1);
      issue(0, 2, 'h20, 0);
      issue(0, 2, 'h28, 0);
      issue(0, 1, 'h28, 0);
      issue(0, 1, 'h00, 1);
`endif
      // randomised traffic including reserved commands, misaligned addresses and resets
      for (int i = 0; i < 3000; i++) begin
         ch_margin = 24'($urandom);
         issue(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, 2'($urandom_range(0, 3)),
               int'($urandom_range(0, 47)), $urandom);
      end
      // counter saturation, then reset in the middle of a burst
      issue(1, 0, 0, 0);
      for (int i = 0; i < (1 << CNT_W) + 3; i++) issue(0, 1, 'h3C, 0);
      issue(0, 2, 'h24, 0);
      issue(0, 2, 'h20, 0);
      issue(0, 1, 'h04, 32'h3F);
      issue(0, 2, 'h3C, 0);
      issue(0, 2, 'h3C, 0);
      issue(1, 2, 'h3C, 0);
      issue(0, 1, 'h3C, 0);
      issue(0, 2, 'h24, 0);
      issue(0, 2, 'h04, 0);
      issue(0, 0, 0, 0);
      issue(0, 0, 0, 0);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain pending_reads=%0d expected=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
